// File: rtl/sram_like_to_axi.sv
// rtl/sram_like_to_axi.sv - bridge from two SRAM-like ports (inst/data) to one single-beat AXI3 master
// Fixed data-first arbitration with at most one AXI transaction outstanding at any time.
module sram_like_to_axi (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR      = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_owner;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_grant;
  logic        w_unused;

  assign w_grant  = data_req | inst_req;
  assign w_unused = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp, r_wr};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_grant) begin
        r_owner   <= data_req;
        r_wr      <= data_req & data_wr;
        r_size    <= data_req ? data_size : inst_size;
        r_addr    <= data_req ? data_addr : inst_addr;
        r_wdata   <= data_req ? data_wdata : 32'd0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_WR) begin
        if (awvalid && awready) r_aw_done <= 1'b1;
        if (wvalid && wready)   r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (data_req)      w_next_state = data_wr ? S_WR : S_RD_ADDR;
        else if (inst_req) w_next_state = S_RD_ADDR;
      end
      S_RD_ADDR: if (arready) w_next_state = S_RD_DATA;
      S_RD_DATA: if (rvalid)  w_next_state = S_IDLE;
      // A done flag or a same-cycle handshake both count as complete.
      S_WR: if ((r_aw_done || awready) && (r_w_done || wready)) w_next_state = S_WR_RESP;
      S_WR_RESP: if (bvalid)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_rdata   = 32'd0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    wstrb        = 4'b0000;
    case (r_state)
      S_IDLE: begin
        data_addr_ok = data_req;
        inst_addr_ok = inst_req & ~data_req;
      end
      S_RD_ADDR: arvalid = 1'b1;
      S_RD_DATA: begin
        rready       = 1'b1;
        inst_data_ok = rvalid & ~r_owner;
        data_data_ok = rvalid & r_owner;
        inst_rdata   = (rvalid & ~r_owner) ? rdata : 32'd0;
        data_rdata   = (rvalid & r_owner) ? rdata : 32'd0;
      end
      S_WR: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        case (r_size)
          2'd0:    wstrb = 4'b0001 << r_addr[1:0];
          2'd1:    wstrb = 4'b0011 << r_addr[1:0];
          default: wstrb = 4'b1111;
        endcase
      end
      S_WR_RESP: begin
        bready       = 1'b1;
        data_data_ok = bvalid;
      end
      default: ;
    endcase
  end

  assign arid    = {3'd0, r_owner};
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = 4'd1;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_size};
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = 4'd1;
  assign wdata   = r_wdata;
  assign wlast   = 1'b1;

endmodule
